// File: rtl/bird_flight_ctrl.sv
// Single-bird flight controller: straight-line motion with bound bounce, LFSR direction changes,
// and hit-fall / escape / timeout sequencing around an erase -> update -> draw handshake with the sprite drawer.
module bird_flight_ctrl #(
  parameter int          X_WIDTH      = 8,
  parameter int          Y_WIDTH      = 7,
  parameter int          X_MIN        = 0,
  parameter int          X_MAX        = 152,
  parameter int          Y_MIN        = 0,
  parameter int          Y_MAX        = 100,
  parameter int          START_X      = 76,
  parameter int          START_Y      = 100,
  parameter int          STEP         = 1,
  parameter int          DIR_HOLD     = 8,
  parameter int          FLIGHT_TICKS = 200,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               launch_i,
  input  logic               shot_i,
  input  logic               out_of_ammo_i,
  input  logic               enable_draw_i,
  output logic [3:0]         state_o,
  output logic [X_WIDTH-1:0] x_o,
  output logic [Y_WIDTH-1:0] y_o,
  output logic               erase_req_o,
  output logic               draw_req_o,
  output logic               bird_active_o,
  output logic               bird_hit_o,
  output logic               bird_escaped_o,
  output logic               done_o
);

  localparam int XW  = X_WIDTH + 1;
  localparam int YW  = Y_WIDTH + 1;
  localparam int FCW = (FLIGHT_TICKS < 1) ? 1 : $clog2(FLIGHT_TICKS + 1);
  localparam int DCW = $clog2(DIR_HOLD + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_HOLD = 4'd1, S_CLEAR = 4'd2, S_UPDATE = 4'd3, S_DRAW = 4'd4, S_DONE = 4'd5
  } state_t;
  typedef enum logic [1:0] {M_FLY = 2'd0, M_FALL = 2'd1, M_ESC = 2'd2} mode_t;

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d, mode_nxt;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic               dx_q, dx_d, dy_q, dy_d;
  logic               hit_latch_q, hit_latch_d, esc_latch_q, esc_latch_d;
  logic [FCW-1:0]     flight_cnt_q, flight_cnt_d;
  logic [DCW-1:0]     dir_cnt_q, dir_cnt_d;
  logic [7:0]         lfsr_q;
  logic               bird_active_q, bird_active_d;
  logic               bird_hit_q, bird_hit_d, bird_escaped_q, bird_escaped_d;
  logic               erase_req_q, draw_req_q, done_q;

  // Moves are evaluated one bit wider so overshoot past a bound is visible before clamping.
  logic [XW-1:0]      x_up;
  logic [YW-1:0]      y_up;
  logic [X_WIDTH-1:0] x_dn;
  logic [Y_WIDTH-1:0] y_dn;
  logic               x_hi, x_lo, y_hi, y_lo;

  assign x_up = {1'b0, x_q} + XW'(STEP);
  assign y_up = {1'b0, y_q} + YW'(STEP);
  assign x_dn = x_q - X_WIDTH'(STEP);
  assign y_dn = y_q - Y_WIDTH'(STEP);
  assign x_hi = (x_up > XW'(X_MAX));
  assign y_hi = (y_up > YW'(Y_MAX));
  assign x_lo = ({1'b0, x_q} < XW'(X_MIN + STEP));
  assign y_lo = ({1'b0, y_q} < YW'(Y_MIN + STEP));

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    mode_nxt       = mode_q;
    x_d            = x_q;
    y_d            = y_q;
    dx_d           = dx_q;
    dy_d           = dy_q;
    hit_latch_d    = hit_latch_q;
    esc_latch_d    = esc_latch_q;
    flight_cnt_d   = flight_cnt_q;
    dir_cnt_d      = dir_cnt_q;
    bird_active_d  = bird_active_q;
    bird_hit_d     = bird_hit_q;
    bird_escaped_d = bird_escaped_q;

    if (mode_q == M_FLY && bird_active_q) begin
      if (shot_i)        hit_latch_d = 1'b1;
      if (out_of_ammo_i) esc_latch_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch_i) begin
          state_d        = S_DRAW;
          mode_d         = M_FLY;
          x_d            = X_WIDTH'(START_X);
          y_d            = Y_WIDTH'(START_Y);
          dx_d           = lfsr_q[0];
          dy_d           = 1'b0;
          hit_latch_d    = 1'b0;
          esc_latch_d    = 1'b0;
          flight_cnt_d   = '0;
          dir_cnt_d      = '0;
          bird_active_d  = 1'b1;
          bird_hit_d     = 1'b0;
          bird_escaped_d = 1'b0;
        end
      end
      S_HOLD:  if (enable_i)      state_d = S_CLEAR;
      S_CLEAR: if (enable_draw_i) state_d = S_UPDATE;
      S_UPDATE: begin
        state_d = S_DRAW;
        if (mode_q == M_FLY) begin
          if (hit_latch_q)
            mode_nxt = M_FALL;
          else if (esc_latch_q || flight_cnt_q == FCW'(FLIGHT_TICKS))
            mode_nxt = M_ESC;
        end
        mode_d = mode_nxt;
        case (mode_nxt)
          M_FLY: begin
            if (dx_q) begin
              if (x_hi) begin x_d = X_WIDTH'(X_MAX); dx_d = 1'b0; end
              else          x_d = x_up[X_WIDTH-1:0];
            end else begin
              if (x_lo) begin x_d = X_WIDTH'(X_MIN); dx_d = 1'b1; end
              else          x_d = x_dn;
            end
            if (dy_q) begin
              if (y_hi) begin y_d = Y_WIDTH'(Y_MAX); dy_d = 1'b0; end
              else          y_d = y_up[Y_WIDTH-1:0];
            end else begin
              if (y_lo) begin y_d = Y_WIDTH'(Y_MIN); dy_d = 1'b1; end
              else          y_d = y_dn;
            end
            flight_cnt_d = flight_cnt_q + FCW'(1);
            // A fresh random heading overrides any bounce flip on the same move.
            if (dir_cnt_q == DCW'(DIR_HOLD - 1)) begin
              dir_cnt_d = '0;
              dx_d      = lfsr_q[0];
              dy_d      = lfsr_q[1];
            end else begin
              dir_cnt_d = dir_cnt_q + DCW'(1);
            end
          end
          M_FALL:  y_d = y_hi ? Y_WIDTH'(Y_MAX) : y_up[Y_WIDTH-1:0];
          M_ESC:   y_d = y_lo ? Y_WIDTH'(Y_MIN) : y_dn;
          default: ;
        endcase
      end
      S_DRAW: begin
        if (enable_draw_i) begin
          if (mode_q == M_FALL && y_q == Y_WIDTH'(Y_MAX)) begin
            state_d       = S_DONE;
            bird_hit_d    = 1'b1;
            bird_active_d = 1'b0;
          end else if (mode_q == M_ESC && y_q == Y_WIDTH'(Y_MIN)) begin
            state_d        = S_DONE;
            bird_escaped_d = 1'b1;
            bird_active_d  = 1'b0;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      mode_q         <= M_FLY;
      x_q            <= X_WIDTH'(START_X);
      y_q            <= Y_WIDTH'(START_Y);
      dx_q           <= 1'b0;
      dy_q           <= 1'b0;
      hit_latch_q    <= 1'b0;
      esc_latch_q    <= 1'b0;
      flight_cnt_q   <= '0;
      dir_cnt_q      <= '0;
      lfsr_q         <= LFSR_SEED;
      bird_active_q  <= 1'b0;
      bird_hit_q     <= 1'b0;
      bird_escaped_q <= 1'b0;
      erase_req_q    <= 1'b0;
      draw_req_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      x_q            <= x_d;
      y_q            <= y_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
      hit_latch_q    <= hit_latch_d;
      esc_latch_q    <= esc_latch_d;
      flight_cnt_q   <= flight_cnt_d;
      dir_cnt_q      <= dir_cnt_d;
      lfsr_q         <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      bird_active_q  <= bird_active_d;
      bird_hit_q     <= bird_hit_d;
      bird_escaped_q <= bird_escaped_d;
      erase_req_q    <= (state_d == S_CLEAR);
      draw_req_q     <= (state_d == S_DRAW);
      done_q         <= (state_d == S_DONE);
    end
  end

  assign state_o        = state_q;
  assign x_o            = x_q;
  assign y_o            = y_q;
  assign erase_req_o    = erase_req_q;
  assign draw_req_o     = draw_req_q;
  assign bird_active_o  = bird_active_q;
  assign bird_hit_o     = bird_hit_q;
  assign bird_escaped_o = bird_escaped_q;
  assign done_o         = done_q;

endmodule

// File: doc/bird_flight_ctrl.md
Name: bird_flight_ctrl

Overview:
- Parametrised successor to the single-bird movement FSM.
- Tracks the bird's X/Y position in registers and moves it in straight lines, bouncing off configurable screen bounds.
- Re-picks direction from an internal LFSR every DIR_HOLD moves and handles the hit-fall, escape and flight-timeout sequences.
- Sits between the game-round controller (launch, shot, out_of_ammo, tick enable) and the VGA sprite drawer (erase/draw requests with an enable_draw completion handshake).

Parameters:
- X_WIDTH, 8: width of x.
- Y_WIDTH, 7: width of y.
- X_MIN, 0; X_MAX, 152: horizontal bounds, inclusive.
- Y_MIN, 0; Y_MAX, 100: vertical bounds, inclusive; y grows downward.
- START_X, 76; START_Y, 100: position loaded on launch and reset.
- STEP, 1: pixels moved per update on each axis.
- DIR_HOLD, 8: FLY updates between direction re-randomisations (>=1).
- FLIGHT_TICKS, 200: FLY updates before forced escape.
- LFSR_SEED, 8'hA5: nonzero LFSR reset value.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  movement tick; one-cycle pulse
- launch  in  1  start a new bird
- shot  in  1  bird hit this cycle
- out_of_ammo  in  1  player out of shells
- enable_draw  in  1  drawer finished the current erase/draw
- state  out  4  current FSM state
- x  out  X_WIDTH  bird position
- y  out  Y_WIDTH  bird position
- erase_req  out  1  erase sprite at x,y
- draw_req  out  1  draw sprite at x,y
- bird_active  out  1  bird in flight/fall/escape
- bird_hit  out  1  sticky result
- bird_escaped  out  1  sticky result
- done  out  1  state==S_DONE

Behaviour:
- Single clock domain; all logic synchronous to clk.
- **Reset** (sync, active-high, overrides everything, any state):
  - state=S_IDLE; x=START_X; y=START_Y.
  - erase_req, draw_req, bird_active, bird_hit, bird_escaped all 0.
  - Latches cleared; counters 0; LFSR=LFSR_SEED.
- **LFSR:** 8-bit Fibonacci, taps 8,6,5,4; advances every clock, not just on enable.
- **State encoding:** S_IDLE=0, S_HOLD=1, S_CLEAR=2, S_UPDATE=3, S_DRAW=4, S_DONE=5. Codes 6-15 go to S_IDLE.
- **S_IDLE / S_DONE:** on launch go to S_DRAW and, in the same edge:
  - load x=START_X, y=START_Y; mode=FLY.
  - dx_right=lfsr[0]; dy_down=0 (bird rises).
  - clear bird_hit, bird_escaped, latches and both counters.
  - launch is ignored in all other states.
- **S_HOLD:** enable=1 -> S_CLEAR; else stay.
- **S_CLEAR:** erase_req=1; stay until enable_draw=1, then S_UPDATE.
- **S_UPDATE:** exactly one cycle, then S_DRAW. Mode is updated first, then motion:
  - Mode priority:
    - FLY with hit_latch -> FALL.
    - FLY with esc_latch, or flight_cnt==FLIGHT_TICKS -> ESCAPE.
  - FLY motion:
    - Each axis moves STEP in its direction.
    - Next value is computed one bit wider. If it passes a bound, clamp to the bound and invert that axis's direction bit.
    - flight_cnt++ and dir_cnt++. When dir_cnt reaches DIR_HOLD: dir_cnt=0, dx_right=lfsr[0], dy_down=lfsr[1].
  - FALL: x unchanged; y=min(y+STEP, Y_MAX).
  - ESCAPE: x unchanged; y=max(y-STEP, Y_MIN).
- **S_DRAW:** draw_req=1; stay until enable_draw=1, then:
  - FALL and y==Y_MAX -> S_DONE, bird_hit=1.
  - ESCAPE and y==Y_MIN -> S_DONE, bird_escaped=1.
  - otherwise S_HOLD.
- **Latches:**
  - hit_latch sets on shot, esc_latch sets on out_of_ammo, in any cycle while mode==FLY and bird_active.
  - Once mode leaves FLY, shot and out_of_ammo are ignored.
  - If both are seen before the same S_UPDATE, the hit wins.
- **bird_active:** 1 from launch until entry to S_DONE.
- **Ignored inputs:** enable outside S_HOLD; enable_draw outside S_CLEAR/S_DRAW.
- **Latency:** enable in S_HOLD with enable_draw held high gives S_CLEAR, S_UPDATE, S_DRAW, S_HOLD, i.e. 4 cycles. The new x/y are valid from the first S_DRAW cycle and never change during S_CLEAR/S_DRAW.
- **Bounds:** a bird sitting exactly on a bound moving outward is clamped there (stays) and its direction flips. No wrap-around ever.

Test Plan:
1. **Reset mid-draw.** Launch, hold enable_draw=0 in S_DRAW, assert reset 1 cycle -> next cycle state=0, x=76, y=100, draw_req=0, bird_active=0.
2. **Bounce** (START_X=151, STEP=2, DIR_HOLD=255, seed chosen so lfsr[0]=1 at launch): one tick -> x=152 and dx flips; next tick -> x=150.
3. **Hit fall** (START_Y=50, STEP=4): launch, one tick, pulse shot -> following ticks step y by +4 per tick until y=100 (last step clamped) -> S_DONE, bird_hit=1, bird_escaped=0, done=1.
4. **Escape** (default params): launch, pulse out_of_ammo -> y falls by 1 per tick to 0 -> bird_escaped=1. A shot during the escape leaves bird_hit=0.
5. **Flight timeout** (FLIGHT_TICKS=3): launch, 3 ticks -> 4th S_UPDATE enters ESCAPE. Also: shot and out_of_ammo in the same cycle -> FALL.
6. **Handshake and ignored launch.** Stall enable_draw low 10 cycles in S_CLEAR -> erase_req stays 1 and x/y are stable. A launch in S_HOLD is ignored. A launch in S_DONE reloads START_X/START_Y and clears bird_hit.
